// File: rtl/fifo_read_prefetch_pkg.sv
// rtl/fifo_read_prefetch_pkg.sv - shared async-FIFO constants for the read-side prefetch stage
package fifo_read_prefetch_pkg;

    // Widths shared with the read/write pointer handlers
    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_POINTER_WIDTH = 3;

    // Buffered-word count encoding for the 2-entry prefetch buffer
    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_0 = 2'd0;
    localparam cnt_t CNT_1 = 2'd1;
    localparam cnt_t CNT_2 = 2'd2;

    // True when another word can be accepted without overrunning the buffer
    function automatic logic cnt_has_room(input cnt_t cnt);
        return (cnt < CNT_2);
    endfunction

endpackage

// File: rtl/fifo_read_prefetch_if.sv
// rtl/fifo_read_prefetch_if.sv - consumer-side valid/ready stream of the read prefetch stage
interface fifo_read_prefetch_if
    import fifo_read_prefetch_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH
) ();

    logic                  out_valid;
    logic [data_width-1:0] out_data;
    logic                  out_ready;

    // Producer side: the prefetch stage
    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    // Consumer side: the crossbar
    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/fifo_read_prefetch_skid_reg.sv
// rtl/fifo_read_prefetch_skid_reg.sv - 2-entry head/tail register pair with enq/deq/flush control
module fifo_out_skid_reg
    import fifo_read_prefetch_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  enq,
    input  logic [data_width-1:0] wdata,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    output cnt_t                  count
);

    cnt_t                  count_q, count_d;
    logic [data_width-1:0] head_q, head_d;
    logic [data_width-1:0] tail_q, tail_d;
    logic                  deq;

    assign deq = (count_q != CNT_0) & out_ready;

    // State register: count plus the head/tail data entries
    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q <= CNT_0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Next-state: occupancy transitions; flush wins and drops everything buffered
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = CNT_0;
        end else begin
            case (count_q)
                CNT_0: begin
                    if (enq) begin
                        count_d = CNT_1;
                    end
                end
                CNT_1: begin
                    if (enq && !deq) begin
                        count_d = CNT_2;
                    end else if (!enq && deq) begin
                        count_d = CNT_0;
                    end
                end
                CNT_2: begin
                    if (deq) begin
                        count_d = CNT_1;
                    end
                end
                default: begin
                    count_d = CNT_0;
                end
            endcase
        end
    end

    // Data path: head always holds the older word; tail is written only when head stays occupied
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (!flush) begin
            case (count_q)
                CNT_0: begin
                    if (enq) begin
                        head_d = wdata;
                    end
                end
                CNT_1: begin
                    if (enq && deq) begin
                        head_d = wdata;
                    end else if (enq) begin
                        tail_d = wdata;
                    end
                end
                CNT_2: begin
                    if (deq) begin
                        head_d = tail_q;
                    end
                end
                default: begin
                    head_d = head_q;
                end
            endcase
        end
    end

    // Outputs come straight from registers so the consumer sees no combinational path
    always_comb begin
        out_valid = (count_q != CNT_0);
        out_data  = head_q;
        count     = count_q;
    end

endmodule

// File: rtl/fifo_read_prefetch.sv
// rtl/fifo_read_prefetch.sv - read-side prefetch stage turning pop/empty into a registered valid/ready stream
module fifo_read_prefetch
    import fifo_read_prefetch_pkg::*;
#(
    parameter int data_width    = DEFAULT_DATA_WIDTH,
    parameter int pointer_width = DEFAULT_POINTER_WIDTH
) (
    input  logic                     clk_rx,
    input  logic                     nrst_rx,
    input  logic                     empty,
    input  logic [pointer_width-1:0] read_pointer,
    output logic [pointer_width-1:0] rd_addr,
    input  logic [data_width-1:0]    rdata,
    output logic                     pop,
    input  logic                     flush,
    output logic [1:0]               occupancy,
    fifo_read_prefetch_if.master     out_if
);

    cnt_t                  count;
    logic                  skid_valid;
    logic [data_width-1:0] skid_data;

    // Pop depends only on local occupancy, never on out_ready, so the handler path stays short
    always_comb begin
        pop       = ~empty & cnt_has_room(count) & ~flush & nrst_rx;
        rd_addr   = read_pointer;
        occupancy = count;
    end

    fifo_out_skid_reg #(
        .data_width (data_width)
    ) u_skid (
        .clk       (clk_rx),
        .nrst      (nrst_rx),
        .enq       (pop),
        .wdata     (rdata),
        .flush     (flush),
        .out_ready (out_if.out_ready),
        .out_valid (skid_valid),
        .out_data  (skid_data),
        .count     (count)
    );

    // Drive the consumer stream from the registered buffer head
    always_comb begin
        out_if.out_valid = skid_valid;
        out_if.out_data  = skid_data;
    end

endmodule

// File: doc/fifo_read_prefetch.md
Name: fifo_read_prefetch

Overview:
- Read-side output stage of the async FIFO, in the rx clock domain, directly downstream of the read pointer handler and the FIFO storage array.
- Converts the handler's pop/empty interface into a registered valid/ready stream for the crossbar consumer.
- Holds a 2-entry prefetch buffer so the consumer sees registered data with no combinational path from out_ready to pop, at full throughput.

Parameters:
- data_width, 32, width of one FIFO word.
- pointer_width, 3, FIFO address width; must match the read pointer handler. Used only for the rd_addr pass-through.

Ports:
- clk_rx  input  1  rx-domain clock.
- nrst_rx  input  1  reset: synchronous, active-low, sampled on posedge clk_rx.
- empty  input  1  from read pointer handler; 1 = no readable word.
- read_pointer  input  pointer_width  from read pointer handler; current read address.
- rd_addr  output  pointer_width  address to storage array; equals read_pointer, combinational.
- rdata  input  data_width  storage array read data; combinational read of rd_addr.
- pop  output  1  to read pointer handler; consumes the word at read_pointer this cycle.
- flush  input  1  synchronous discard of buffered words.
- out_valid  output  1  consumer-side valid, registered.
- out_data  output  data_width  consumer-side data, registered.
- out_ready  input  1  consumer-side ready.
- occupancy  output  2  buffered word count, 0..2.

Behaviour:
- Reset (nrst_rx=0 at posedge): count=0, out_valid=0, out_data=0, tail register=0, occupancy=0. pop=0 while nrst_rx=0.
- pop = ~empty & (count<2) & ~flush & nrst_rx. Purely combinational from these signals; it must not depend on out_ready.
- Storage: head register drives out_data. Tail register is the second entry. out_valid = (count!=0).
- deq = out_valid & out_ready. enq = pop. rdata is captured in the same cycle pop is high.
- Count-state transitions at posedge:
  - count0, enq: head<=rdata; count1.
  - count1, enq only: tail<=rdata; count2.
  - count1, deq only: count0.
  - count1, enq & deq: head<=rdata; count1.
  - count2, deq: head<=tail; count1. No enq is possible, since pop=0.
  - No event: hold all registers.
- Latency: a word popped in cycle N appears on out_data/out_valid in cycle N+1.
- Throughput: sustained 1 word/cycle while empty=0 and out_ready=1 (count stays 1).
- Ordering: strict FIFO; head is always the older entry.
- out_data is held stable while out_valid=1 and out_ready=0. It changes only on deq or enq-into-empty.
- Backpressure: at count2, pop stays 0 regardless of empty. The read pointer does not advance.
- flush=1 at posedge: count<=0 and out_valid<=0. pop=0 that cycle, so no word is lost from the FIFO array. Already-buffered words are discarded. A deq in the same cycle is still counted as accepted by the consumer. Data registers may hold stale values.
- Reset mid-operation: buffered words are lost. Handler reset in the same domain realigns the pointers.
- empty toggling from pointer synchronisation is tolerated: pop follows the current-cycle empty only.
- occupancy = count.

Decomposition:
- Shared async-FIFO package: count encoding constants CNT_0/CNT_1/CNT_2 (2-bit), plus the default data_width and pointer_width shared with the pointer handlers.
- One sub-module is natural: fifo_out_skid_reg, the 2-entry head/tail register pair with enq/deq/flush control.
- The top-level module adds pop generation and the rd_addr pass-through.

Test Plan:
- Reset: hold nrst_rx=0 for 3 cycles with empty=0 -> pop=0, out_valid=0, out_data=0, occupancy=0. Release -> pop=1 in the first cycle.
- Streaming: empty=0, rdata=0xA0,0xA1,0xA2,... per pop, out_ready=1 -> out_data = 0xA0 one cycle after the first pop, then one word per cycle in order. occupancy stays 1.
- Backpressure: out_ready=0, empty=0, rdata 0x10,0x11,0x12 -> exactly 2 pops. occupancy=2, out_data=0x10 stable, pop=0 from then on. Raise out_ready -> outputs 0x10, 0x11, then 0x12 after refill, with no duplicates or drops.
- Empty boundary: one word 0x55 available (empty=0 for one cycle only) -> single pop, out_valid=1 with 0x55 next cycle. After deq, out_valid=0 and pop=0.
- Flush: occupancy=2 (0x20,0x21), flush=1 with empty=0 -> pop=0 that cycle, out_valid=0 next cycle. The next pop delivers the word at the unchanged read_pointer.
- Simultaneous: count1 with enq & deq for 4 cycles (0x30..0x33) -> out_data advances each cycle, count stays 1, and the tail register is never written.
